// File: rtl/output_selecter.sv
// output_selecter: return-path end of the 4x4 2D-FFT selector pair.
// Captures each butterfly pass, feeds pass-1 results back on rt_out with sel=1,
// and presents pass-2 results on a valid/ready port while counting delivered frames.
// Optional feature: define OUTSEL_SCALE_EN to scale each captured component by 1/4
// (round half up); otherwise capture is a plain copy.
module output_selecter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [32*DATA_W-1:0]   in_data,
    output logic                   sel,
    output logic [32*DATA_W-1:0]   rt_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [32*DATA_W-1:0]   out_data,
    output logic                   busy,
    output logic                   drop_err,
    output logic [CNT_W-1:0]       frame_cnt
);

    localparam int unsigned BUS_W = 32 * DATA_W;
    localparam int unsigned N_CMP = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT1 = 3'd1,
        S_RET   = 3'd2,
        S_WAIT2 = 3'd3,
        S_OUT   = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic               sel_q, sel_d;
    logic               busy_q, busy_d;
    logic               out_valid_q, out_valid_d;
    logic               drop_err_q, drop_err_d;
    logic [BUS_W-1:0]   rt_out_q, rt_out_d;
    logic [BUS_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

`ifdef OUTSEL_SCALE_EN
    localparam int unsigned TW = DATA_W + 1;

    // Per-component (x + 2) >>> 2 evaluated one bit wider so +2 cannot overflow.
    function automatic logic [BUS_W-1:0] capture_xform(input logic [BUS_W-1:0] x);
        logic [BUS_W-1:0] res;
        logic [TW-1:0]    t;
        res = '0;
        for (int k = 0; k < int'(N_CMP); k++) begin
            t = {x[k*DATA_W + DATA_W - 1], x[k*DATA_W +: DATA_W]} + TW'(2);
            res[k*DATA_W +: DATA_W] = {t[TW-1], t[TW-1:2]};
        end
        return res;
    endfunction
`else
    // Index-preserving copy; the transpose lives in input_selecter.
    function automatic logic [BUS_W-1:0] capture_xform(input logic [BUS_W-1:0] x);
        return x;
    endfunction
`endif

    // Next-state, capture and output decode. An in_valid in a state that does not
    // expect data only flags drop_err and freezes the state for that cycle.
    always_comb begin
        state_d     = state_q;
        rt_out_d    = rt_out_q;
        out_data_d  = out_data_q;
        drop_err_d  = drop_err_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    drop_err_d = 1'b1;
                end else if (start) begin
                    drop_err_d = 1'b0;
                    state_d    = S_WAIT1;
                end
            end
            S_WAIT1: begin
                if (in_valid) begin
                    rt_out_d = capture_xform(in_data);
                    state_d  = S_RET;
                end
            end
            S_RET: begin
                if (in_valid) begin
                    drop_err_d = 1'b1;
                end else begin
                    state_d = S_WAIT2;
                end
            end
            S_WAIT2: begin
                if (in_valid) begin
                    out_data_d = capture_xform(in_data);
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (in_valid) begin
                    drop_err_d = 1'b1;
                end else if (out_ready) begin
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    if (start) begin
                        drop_err_d = 1'b0;
                        state_d    = S_WAIT1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        sel_d       = (state_d == S_RET) || (state_d == S_WAIT2);
        busy_d      = (state_d != S_IDLE);
        out_valid_d = (state_d == S_OUT);
    end

    // State and output registers; reset clears everything, dropping sel at once.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q     <= S_IDLE;
            sel_q       <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            drop_err_q  <= 1'b0;
            rt_out_q    <= '0;
            out_data_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            drop_err_q  <= drop_err_d;
            rt_out_q    <= rt_out_d;
            out_data_q  <= out_data_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign sel       = sel_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign drop_err  = drop_err_q;
    assign rt_out    = rt_out_q;
    assign out_data  = out_data_q;
    assign frame_cnt = frame_cnt_q;

endmodule
